// File: rtl/rf_mover.sv
// Row-move engine: copies a run of rows src->dst over the register file's single-port bus.
// Three cycles per row (read, capture, write); one-cycle FIN with done; commands accepted only in IDLE.
module rf_mover #(
  parameter int DATA_W = 1408,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_src_fix,
  input  logic              cmd_dst_fix,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_q,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  rows_done
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    rows_q, rows_d;
  logic                src_fix_q, src_fix_d;
  logic                dst_fix_q, dst_fix_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_d_q, rf_d_d;
  logic                rf_we_q, rf_we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   src_nxt;

  assign src_nxt = src_fix_q ? src_q : src_q + ADDR_W'(1);

  // Bus outputs are registered from the next state so each state drives its own bus values.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    rows_d    = rows_q;
    src_fix_d = src_fix_q;
    dst_fix_d = dst_fix_q;
    rf_addr_d = rf_addr_q;
    rf_d_d    = rf_d_q;
    rf_we_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          src_d     = cmd_src;
          dst_d     = cmd_dst;
          rem_d     = cmd_len;
          src_fix_d = cmd_src_fix;
          dst_fix_d = cmd_dst_fix;
          rows_d    = '0;
          if (cmd_len == '0) begin
            state_d = FIN;
          end else begin
            state_d   = RD;
            rf_addr_d = cmd_src;
          end
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        // rf_q now holds the row addressed during RD; it becomes the write data.
        state_d   = WR;
        rf_addr_d = dst_q;
        rf_d_d    = rf_q;
        rf_we_d   = 1'b1;
      end
      WR: begin
        rows_d = rows_q + LEN_W'(1);
        rem_d  = rem_q - LEN_W'(1);
        src_d  = src_nxt;
        if (!dst_fix_q) dst_d = dst_q + ADDR_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = FIN;
        end else begin
          state_d   = RD;
          rf_addr_d = src_nxt;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      rows_q    <= '0;
      src_fix_q <= 1'b0;
      dst_fix_q <= 1'b0;
      rf_addr_q <= '0;
      rf_d_q    <= '0;
      rf_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      rows_q    <= rows_d;
      src_fix_q <= src_fix_d;
      dst_fix_q <= dst_fix_d;
      rf_addr_q <= rf_addr_d;
      rf_d_q    <= rf_d_d;
      rf_we_q   <= rf_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rf_addr   = rf_addr_q;
  assign rf_d      = rf_d_q;
  assign rf_we     = rf_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rows_done = rows_q;

endmodule

// File: tb/tb_rf_mover.sv
// Bench for rf_mover: synchronous-read RAM model, table vectors, random moves vs. a row-copy model.
module tb_rf_mover;
  localparam int DW = 1408;
  localparam int AW = 9;
  localparam int LW = 9;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    bit            sf;
    bit            df;
    bit            hold;
    int            exp_lat;
    int            exp_rows;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_src_fix = 1'b0;
  logic          cmd_dst_fix = 1'b0;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d;
  logic          rf_we;
  logic [DW-1:0] rf_q;
  logic          busy;
  logic          done;
  logic [LW-1:0] rows_done;

  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_dat = '0;

  logic [DW-1:0] mem     [0:511];
  logic [DW-1:0] ref_mem [0:511];
  wr_t           obs[$];
  wr_t           expq[$];
  int            total = 0;
  int            bad = 0;

  rf_mover #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_src_fix(cmd_src_fix), .cmd_dst_fix(cmd_dst_fix),
    .rf_addr(rf_addr), .rf_d(rf_d), .rf_we(rf_we), .rf_q(rf_q),
    .busy(busy), .done(done), .rows_done(rows_done)
  );

  always #5 clk = ~clk;

  // Register file: data appears on rf_q one cycle after the address.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_dat;
    else if (rf_we) mem[rf_addr] <= rf_d;
    rf_q <= mem[rf_addr];
  end

  always @(negedge clk) begin
    if (rf_we) obs.push_back('{rf_addr, rf_d});
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: sequential row copies straight from the command fields.
  task automatic model(input vec_t v);
    logic [AW-1:0] s, d;
    for (int i = 0; i < int'(v.len); i++) begin
      s = v.sf ? v.src : v.src + AW'(i);
      d = v.df ? v.dst : v.dst + AW'(i);
      ref_mem[d] = ref_mem[s];
      expq.push_back('{d, ref_mem[s]});
    end
  endtask

  task automatic issue(input vec_t v, input string tag);
    @(negedge clk);
    check({tag, "_ready_idle"}, cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_src     = v.src;
    cmd_dst     = v.dst;
    cmd_len     = v.len;
    cmd_src_fix = v.sf;
    cmd_dst_fix = v.df;
    @(posedge clk);
    #1;
    if (!v.hold) cmd_valid = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    int nbad = 0;
    check({tag, "_nwrites"}, obs.size(), expq.size());
    for (int i = 0; i < expq.size() && i < obs.size(); i++)
      if (obs[i].a !== expq[i].a || obs[i].d !== expq[i].d) nbad++;
    check({tag, "_wr_mismatch"}, nbad, 0);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int lat = -1, busy_cnt = 0, rdy_err = 0;
    obs.delete();
    expq.delete();
    model(v);
    issue(v, tag);
    for (int n = 1; n <= int'(v.len) * 3 + 20 && lat < 0; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (cmd_ready == busy) rdy_err++;
      if (done) begin
        lat = n;
        cmd_valid = 1'b0;
      end
    end
    check({tag, "_latency"}, lat, v.exp_lat);
    @(negedge clk);
    check({tag, "_done_single"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_ready_after"}, cmd_ready, 1);
    #1;
    check({tag, "_busy_cycles"}, busy_cnt, v.exp_lat);
    check({tag, "_ready_vs_busy"}, rdy_err, 0);
    check({tag, "_rows_done"}, rows_done, v.exp_rows);
    compare_writes(tag);
  endtask

  initial begin
    vec_t          tbl[6];
    vec_t          v, vpart;
    logic [DW-1:0] row, x_row;
    int            nbad, dcnt;

    tbl[0] = '{9'h010, 9'h020, 9'd4, 1'b0, 1'b0, 1'b0, 13, 4};
    tbl[1] = '{9'h050, 9'h060, 9'd0, 1'b0, 1'b0, 1'b0,  1, 0};
    tbl[2] = '{9'h1FE, 9'h005, 9'd3, 1'b0, 1'b0, 1'b0, 10, 3};
    tbl[3] = '{9'h040, 9'h100, 9'd4, 1'b0, 1'b1, 1'b1, 13, 4};
    tbl[4] = '{9'h030, 9'h031, 9'd3, 1'b0, 1'b0, 1'b0, 10, 3};
    tbl[5] = '{9'h110, 9'h070, 9'd3, 1'b1, 1'b0, 1'b0, 10, 3};

    #3 rst_n = 1'b0;
    #1;
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_d_nonzero", (rf_d != '0), 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rows_done", rows_done, 0);

    for (int a = 0; a < 512; a++) begin
      for (int w = 0; w < DW / 32; w++) row[w*32 +: 32] = $urandom();
      ref_mem[a] = row;
      @(negedge clk);
      pl_we = 1'b1;
      pl_addr = AW'(a);
      pl_dat = row;
    end
    @(negedge clk);
    pl_we = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    x_row = ref_mem[9'h030];
    for (int i = 0; i < 6; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

    nbad = 0;
    for (int a = 9'h031; a <= 9'h033; a++) if (mem[a] !== x_row) nbad++;
    check("overlap_propagate", nbad, 0);
    check("fixdst_port_last", (mem[9'h100] === ref_mem[9'h043]), 1);

    // Reset during CAP of row 2 of a 5-row move: rows 0 and 1 already written.
    v = '{9'h080, 9'h0A0, 9'd5, 1'b0, 1'b0, 1'b0, 16, 5};
    vpart = v;
    vpart.len = 9'd2;
    obs.delete();
    expq.delete();
    model(vpart);
    issue(v, "rstmid");
    repeat (8) @(negedge clk);
    check("rstmid_rows_before", rows_done, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_rf_we", rf_we, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_rows_done", rows_done, 0);
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("rstmid_no_done", dcnt, 0);
    check("rstmid_ready", cmd_ready, 1);
    compare_writes("rstmid");
    run_cmd('{9'h0C0, 9'h0D0, 9'd2, 1'b0, 1'b0, 1'b0, 7, 2}, "after_rst");

    for (int i = 0; i < 24; i++) begin
      v.src  = AW'($urandom_range(0, 511));
      v.dst  = AW'($urandom_range(0, 511));
      v.len  = LW'($urandom_range(0, 8));
      v.sf   = ($urandom_range(0, 3) == 0);
      v.df   = ($urandom_range(0, 3) == 0);
      v.hold = ($urandom_range(0, 1) == 1);
      v.exp_lat  = 3 * int'(v.len) + 1;
      v.exp_rows = int'(v.len);
      run_cmd(v, $sformatf("rnd%0d", i));
    end

    nbad = 0;
    for (int a = 0; a < 512; a++) if (mem[a] !== ref_mem[a]) nbad++;
    check("final_mem_image", nbad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_mover.md
Name: rf_mover

Overview:
- Initiator-side row-move engine for the register file: owns the register file's single-port access bus (rf_addr, rf_d, rf_we, rf_q).
- Copies a run of DATA_W-bit rows from a source address to a destination address, one row at a time.
- Because the accelerator X/Y ports are memory-mapped (0x100-0x133), the same engine streams rows into or out of StMM and LayerNorm ports as well as RAM-to-RAM.
- Sits between the instruction sequencer (command side) and the register file (bus side).

Parameters:
- DATA_W, 1408, row width in bits (176 bytes).
- ADDR_W, 9, register-file address width (bit 8 set = memory-mapped IO space).
- LEN_W, 9, row-count width; max move = 2^LEN_W-1 rows.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command (high only in IDLE).
- cmd_src  in  ADDR_W  first source row address.
- cmd_dst  in  ADDR_W  first destination row address.
- cmd_len  in  LEN_W  number of rows to move.
- cmd_src_fix  in  1  1: source address held constant (reading a Y port); 0: increment per row.
- cmd_dst_fix  in  1  1: destination address held constant (feeding an X port); 0: increment per row.
- rf_addr  out  ADDR_W  register-file address.
- rf_d  out  DATA_W  register-file write data.
- rf_we  out  1  register-file write strobe.
- rf_q  in  DATA_W  register-file read data; valid one cycle after the address is presented.
- busy  out  1  high from command accept until the done pulse, inclusive.
- done  out  1  single-cycle pulse when a command completes.
- rows_done  out  LEN_W  rows written for the current/last command.

Behaviour:
- Reset (async assert, sync-released use):
  - FSM to IDLE; rf_addr=0, rf_d=0, rf_we=0.
  - busy=0, done=0, cmd_ready=1 (combinational from IDLE), rows_done=0.
  - Reset mid-move abandons the command; no further writes occur and no done pulse is issued.
- Command accept: in IDLE, when cmd_valid && cmd_ready, latch src, dst, len, fix flags; clear rows_done; set busy the next cycle.
- States: IDLE, RD, CAP, WR, FIN.
- Transitions:
  - IDLE -> RD on accept with len != 0.
  - IDLE -> FIN on accept with len == 0; no bus activity.
  - RD -> CAP -> WR unconditionally.
  - WR -> RD if remaining rows > 0 after this write, else WR -> FIN.
  - FIN -> IDLE.
- Per-row bus activity (3 cycles/row; all outputs registered, driven in-state):
  - RD: rf_addr = cur_src, rf_we = 0.
  - CAP: rf_addr held at cur_src, rf_we = 0; buf <= rf_q at the end of the cycle.
  - WR: rf_addr = cur_dst, rf_d = buf, rf_we = 1 for exactly one cycle.
  - At the end of WR: rows_done += 1; cur_src += 1 unless src_fix; cur_dst += 1 unless dst_fix.
  - Addresses wrap modulo 2^ADDR_W (0x1FF -> 0x000).
- rf_we is never asserted outside WR. rf_addr holds its last value in IDLE/FIN.
- FIN: done = 1 for one cycle; busy = 1 in FIN, 0 in IDLE.
- Total command latency: accept edge to done = 3*len + 1 cycles; for len=0, done is asserted the cycle after accept.
- Overlap: rows are strictly sequential and ascending, each read completes before its write. src < dst overlap therefore propagates (defined behaviour, not an error).
- Fixed source on a Y port re-reads the same port every row. Fixed destination on an X port produces len ld pulses in the register file, 3 cycles apart.
- cmd_valid while busy is ignored (cmd_ready=0); the command must be held until accepted.
- rf_d keeps its last written value when not in WR (no toggling).

Test Plan:
- Reset, then move src=0x010 dst=0x020 len=4 (both fix=0), RAM model preloaded with rows 0x10-0x13 = A,B,C,D -> rows 0x20-0x23 = A,B,C,D; 4 rf_we pulses; done 13 cycles after accept; rows_done=4.
- len=0 accept -> done one cycle later; rf_we never asserted; rows_done=0; busy high for exactly one cycle.
- src=0x1FE dst=0x005 len=3 -> reads at 0x1FE, 0x1FF, 0x000 (wrap); writes at 0x005-0x007.
- dst=0x100 dst_fix=1, src=0x040 len=4 -> four writes, all with rf_addr=0x100, carrying rows 0x40-0x43 in order; cmd_ready=0 throughout.
- Overlap src=0x030 dst=0x031 len=3, row 0x30 = X -> rows 0x31, 0x32, 0x33 all equal X.
- Assert rst_n=0 during the CAP of row 2 of a len=5 move -> rf_we=0 immediately; no done pulse; after release, cmd_ready=1 and a new command completes normally.
